imem_boot_ctrl: RTL and testbench



---
 rtl/imem_pkg.sv | 15 +
 rtl/imem_ram.sv | 26 ++
 rtl/imem_boot_ctrl.sv | 119 +++++++++++
 tb/tb_imem_boot_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and defaults for the instruction-memory boot controller.
// The core is held on a NOP while the memory is cleared and loaded.
package imem_pkg;

    localparam int          IMEM_ADDR_W   = 5;
    localparam int          IMEM_DEPTH    = 32;
    localparam logic [31:0] IMEM_NOP_WORD = 32'h00000013;

    typedef enum logic [1:0] {
        CLEAR,
        LOAD,
        RUN
    } imem_state_t;

endpackage

// File: rtl/imem_ram.sv
// DEPTH x 32 instruction store: one clocked write port, asynchronous read.
// The array has no reset; the boot controller zero-fills it after reset.
module imem_ram #(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Combinational fetch so the single-cycle core sees the word in the same cycle.
    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot controller: zero-clears the instruction memory, loads a program from the
// host stream, then releases the core and serves fetches at pc_addr.
module imem_boot_ctrl
    import imem_pkg::*;
#(
    parameter int          ADDR_W   = IMEM_ADDR_W,
    parameter int          DEPTH    = IMEM_DEPTH,
    parameter logic [31:0] NOP_WORD = IMEM_NOP_WORD
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [31:0]       ld_data,
    input  logic              ld_last,
    input  logic              reload,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic [31:0]       inst,
    output logic              core_run,
    output logic [ADDR_W:0]   words_loaded,
    output logic              trunc
);

    imem_state_t       state;
    imem_state_t       state_next;
    logic [ADDR_W-1:0] clr_ptr;
    logic [ADDR_W-1:0] wr_ptr;
    logic              accept;
    logic              clr_at_end;
    logic              wr_at_end;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    assign ld_ready   = (state == LOAD);
    assign accept     = ld_valid & ld_ready;
    assign core_run   = (state == RUN);
    assign clr_at_end = (clr_ptr == ADDR_W'(DEPTH - 1));
    assign wr_at_end  = (wr_ptr == ADDR_W'(DEPTH - 1));
    assign inst       = core_run ? ram_rdata : NOP_WORD;

    // The single RAM write port is shared by the clear sweep and the host loader.
    always_comb begin
        state_next = state;
        ram_we     = 1'b0;
        ram_waddr  = wr_ptr;
        ram_wdata  = ld_data;
        unique case (state)
            CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = clr_ptr;
                ram_wdata = '0;
                if (clr_at_end) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                ram_we = accept;
                if (accept && (ld_last || wr_at_end)) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (reload) begin
                    state_next = CLEAR;
                end
            end
            default: state_next = CLEAR;
        endcase
    end

    // Filling the last word without ld_last ends the load and flags truncation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= CLEAR;
            clr_ptr      <= '0;
            wr_ptr       <= '0;
            words_loaded <= '0;
            trunc        <= 1'b0;
        end else begin
            state <= state_next;
            unique case (state)
                CLEAR: clr_ptr <= clr_ptr + ADDR_W'(1);
                LOAD: begin
                    if (accept) begin
                        wr_ptr       <= wr_ptr + ADDR_W'(1);
                        words_loaded <= words_loaded + (ADDR_W + 1)'(1);
                        if (wr_at_end && !ld_last) begin
                            trunc <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (reload) begin
                        clr_ptr      <= '0;
                        wr_ptr       <= '0;
                        words_loaded <= '0;
                        trunc        <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    imem_ram #(
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .waddr(ram_waddr),
        .wdata(ram_wdata),
        .raddr(pc_addr),
        .rdata(ram_rdata)
    );

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Testbench for imem_boot_ctrl: directed vector table, hand-written corner
// sequences and a randomized run checked against a behavioural model.
module tb_imem_boot_ctrl;

    localparam int          DEPTH = 32;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_data;
    logic        ld_last;
    logic        reload;
    logic [4:0]  pc_addr;
    logic [31:0] inst;
    logic        core_run;
    logic [5:0]  words_loaded;
    logic        trunc;

    int vectors     = 0;
    int miscompares = 0;

    // Model: clear countdown, run flag, word array and load statistics.
    int          m_clear_left;
    bit          m_running;
    logic [31:0] m_mem [DEPTH];
    int          m_count;
    bit          m_trunc;

    typedef struct {
        logic        valid;
        logic [31:0] data;
        logic        last;
        logic [4:0]  pc;
        logic        exp_ready;
        logic        exp_run;
        logic [31:0] exp_inst;
        int          exp_wl;
    } vec_t;

    vec_t table_v [11];

    always #5 clk = ~clk;

    imem_boot_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .reload      (reload),
        .pc_addr     (pc_addr),
        .inst        (inst),
        .core_run    (core_run),
        .words_loaded(words_loaded),
        .trunc       (trunc)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        bit loading;
        loading = (m_clear_left == 0) && !m_running;
        check("ld_ready", 32'(ld_ready), 32'(loading));
        check("core_run", 32'(core_run), 32'(m_running));
        check("inst", inst, m_running ? m_mem[pc_addr] : NOP);
        check("words_loaded", 32'(words_loaded), 32'(m_count));
        check("trunc", 32'(trunc), 32'(m_trunc));
    endtask

    task automatic modelReset();
        m_clear_left = DEPTH;
        m_running    = 1'b0;
        m_count      = 0;
        m_trunc      = 1'b0;
    endtask

    task automatic applyStimulus(input logic r, input logic v, input logic [31:0] d,
                                 input logic l, input logic rl, input logic [4:0] pc);
        @(negedge clk);
        rst_n    = r;
        ld_valid = v;
        ld_data  = d;
        ld_last  = l;
        reload   = rl;
        pc_addr  = pc;
        #1;
        checkOutput();
    endtask

    // Advance across the rising edge and apply the controller's rules to the model.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            modelReset();
        end else if (m_clear_left > 0) begin
            m_mem[DEPTH - m_clear_left] = 32'h0;
            m_clear_left--;
        end else if (!m_running) begin
            if (ld_valid) begin
                m_mem[m_count] = ld_data;
                m_count++;
                if (ld_last) begin
                    m_running = 1'b1;
                end else if (m_count == DEPTH) begin
                    m_running = 1'b1;
                    m_trunc   = 1'b1;
                end
            end
        end else if (reload) begin
            modelReset();
        end
    endtask

    task automatic cycle(input logic r, input logic v, input logic [31:0] d,
                         input logic l, input logic rl, input logic [4:0] pc);
        applyStimulus(r, v, d, l, rl, pc);
        tick();
    endtask

    task automatic idleClear();
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 5'(i));
        end
    endtask

    initial begin
        rst_n = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
        reload = 1'b0; pc_addr = '0;
        repeat (2) @(posedge clk);
        modelReset();

        // Idle host after reset: held for exactly DEPTH cycles.
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 5'(i));
            check("clear_ready", 32'(ld_ready), 32'h0);
            check("clear_inst", inst, NOP);
            tick();
        end

        // Three-word program with host valid gaps, then fetches and an ignored word.
        table_v[0]  = '{1'b1, 32'h00300413, 1'b0, 5'd0, 1'b1, 1'b0, NOP, 0};
        table_v[1]  = '{1'b0, 32'h11111111, 1'b0, 5'd0, 1'b1, 1'b0, NOP, 1};
        table_v[2]  = '{1'b0, 32'h22222222, 1'b1, 5'd0, 1'b1, 1'b0, NOP, 1};
        table_v[3]  = '{1'b1, 32'h00100493, 1'b0, 5'd1, 1'b1, 1'b0, NOP, 1};
        table_v[4]  = '{1'b1, 32'h01000913, 1'b1, 5'd1, 1'b1, 1'b0, NOP, 2};
        table_v[5]  = '{1'b0, 32'h0,        1'b0, 5'd1, 1'b0, 1'b1, 32'h00100493, 3};
        table_v[6]  = '{1'b0, 32'h0,        1'b0, 5'd0, 1'b0, 1'b1, 32'h00300413, 3};
        table_v[7]  = '{1'b0, 32'h0,        1'b0, 5'd2, 1'b0, 1'b1, 32'h01000913, 3};
        table_v[8]  = '{1'b0, 32'h0,        1'b0, 5'd5, 1'b0, 1'b1, 32'h0, 3};
        table_v[9]  = '{1'b1, 32'hFFFFFFFF, 1'b1, 5'd3, 1'b0, 1'b1, 32'h0, 3};
        table_v[10] = '{1'b0, 32'h0,        1'b0, 5'd3, 1'b0, 1'b1, 32'h0, 3};
        for (int i = 0; i < 11; i++) begin
            applyStimulus(1'b1, table_v[i].valid, table_v[i].data, table_v[i].last, 1'b0, table_v[i].pc);
            check($sformatf("tbl%0d_ready", i), 32'(ld_ready), 32'(table_v[i].exp_ready));
            check($sformatf("tbl%0d_run", i), 32'(core_run), 32'(table_v[i].exp_run));
            check($sformatf("tbl%0d_inst", i), inst, table_v[i].exp_inst);
            check($sformatf("tbl%0d_wl", i), 32'(words_loaded), 32'(table_v[i].exp_wl));
            tick();
        end

        // Reload from RUN, then a one-word program replaces the old one.
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 5'd0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0);
        check("reload_run", 32'(core_run), 32'h0);
        check("reload_wl", 32'(words_loaded), 32'h0);
        tick();
        for (int i = 1; i < DEPTH; i++) begin
            cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0);
        end
        cycle(1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 5'd0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0);
        check("reload_pc0", inst, 32'hDEADBEEF);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 5'd2);
        check("reload_pc2", inst, 32'h0);
        tick();

        // Truncated load: DEPTH words with no last, then a further word is refused.
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 5'd0);
        idleClear();
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 1'b1, $urandom, 1'b0, 1'b0, 5'(i));
        end
        applyStimulus(1'b1, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0, 5'd31);
        check("trunc_flag", 32'(trunc), 32'h1);
        check("trunc_wl", 32'(words_loaded), 32'd32);
        check("trunc_run", 32'(core_run), 32'h1);
        check("trunc_ready", 32'(ld_ready), 32'h0);
        tick();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b1, $urandom, 1'b0, 1'b0, 5'($urandom_range(0, 31)));
        end

        // Reset in the middle of a load discards the partial program.
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 5'd0);
        idleClear();
        cycle(1'b1, 1'b1, 32'hAAAA0001, 1'b0, 1'b0, 5'd0);
        cycle(1'b1, 1'b1, 32'hAAAA0002, 1'b0, 1'b0, 5'd0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0);
        check("rst_wl", 32'(words_loaded), 32'h0);
        check("rst_ready", 32'(ld_ready), 32'h0);
        tick();
        for (int i = 1; i < DEPTH; i++) begin
            cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0);
        end
        cycle(1'b1, 1'b1, 32'h12345678, 1'b1, 1'b0, 5'd0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 5'd1);
        check("rst_old_word", inst, 32'h0);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0);
        check("rst_new_word", inst, 32'h12345678);
        tick();

        // Randomized traffic, including reloads and resets in every phase.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 299) != 0),
                  ($urandom_range(0, 2) != 0),
                  $urandom,
                  ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 39) == 0),
                  5'($urandom_range(0, 31)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
